// File: rtl/src_phase_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | src_phase_scheduler: round-robin L/M polyphase command sequencer        |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
module src_phase_scheduler #(
  parameter int NR_STREAMS     = 16,
  parameter int NR_STREAMS_LOG = 4,
  parameter int L              = 160,
  parameter int M              = 147,
  parameter int PHASE_BITS     = 8,
  parameter int CREDIT_BITS    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      frame_in,
  output logic                      frame_rdy,
  output logic                      cmd_req,
  input  logic                      cmd_ack,
  output logic [NR_STREAMS_LOG-1:0] cmd_stream,
  output logic [PHASE_BITS-1:0]     cmd_phase,
  output logic                      cmd_shift,
  output logic                      cmd_first,
  output logic                      overflow
);

  localparam int                        SUM_BITS    = PHASE_BITS + 1;
  localparam logic [SUM_BITS-1:0]       L_SUM       = SUM_BITS'(L);
  localparam logic [SUM_BITS-1:0]       M_SUM       = SUM_BITS'(M);
  localparam logic [CREDIT_BITS-1:0]    CREDIT_MAX  = '1;
  localparam logic [NR_STREAMS_LOG-1:0] LAST_STREAM = NR_STREAMS_LOG'(NR_STREAMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t                      state_q;
  logic                        req_q;
  logic [NR_STREAMS_LOG-1:0]   stream_q;
  logic [PHASE_BITS-1:0]       phase_q;
  logic                        shift_q;
  logic                        first_q;
  logic                        overflow_q;
  logic [CREDIT_BITS-1:0]      credits_q;
  logic [CREDIT_BITS-1:0]      credits_d;
  logic                        overflow_set;

  // One extra bit so phase+M (up to 2L-2) never wraps before the compare.
  logic [SUM_BITS-1:0]         phase_sum;
  logic                        shift_now;
  logic [PHASE_BITS-1:0]       phase_next;
  logic                        consume;

  assign phase_sum  = {1'b0, phase_q} + M_SUM;
  assign shift_now  = (phase_sum >= L_SUM);
  assign phase_next = shift_now ? PHASE_BITS'(phase_sum - L_SUM) : PHASE_BITS'(phase_sum);
  assign consume    = (state_q == S_CHECK) && shift_now && (credits_q != '0);

  // A frame arriving in the same cycle as a consume cancels out.
  always_comb begin
    credits_d    = credits_q;
    overflow_set = 1'b0;
    if (frame_in && !consume) begin
      if (credits_q != CREDIT_MAX) begin
        credits_d = credits_q + CREDIT_BITS'(1);
      end else begin
        overflow_set = 1'b1;
      end
    end else if (!frame_in && consume) begin
      credits_d = credits_q - CREDIT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      stream_q   <= '0;
      phase_q    <= '0;
      shift_q    <= 1'b0;
      first_q    <= 1'b0;
      overflow_q <= 1'b0;
      credits_q  <= '0;
    end else begin
      credits_q <= credits_d;
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!shift_now || credits_q != '0) begin
            state_q  <= S_ISSUE;
            req_q    <= 1'b1;
            stream_q <= '0;
            shift_q  <= shift_now;
            first_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (cmd_ack) begin
            first_q <= 1'b0;
            if (stream_q == LAST_STREAM) begin
              stream_q <= '0;
              phase_q  <= phase_next;
              req_q    <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              stream_q <= stream_q + NR_STREAMS_LOG'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign frame_rdy  = (credits_q != CREDIT_MAX);
  assign cmd_req    = req_q;
  assign cmd_stream = stream_q;
  assign cmd_phase  = phase_q;
  assign cmd_shift  = shift_q;
  assign cmd_first  = first_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_src_phase_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for src_phase_scheduler: random ack/frame stimulus against a closed-form
// phase model ((round*M) mod L) and a credit-count round predictor.
module tb_src_phase_scheduler;

  localparam int NS  = 16;
  localparam int NSL = 4;
  localparam int LL  = 160;
  localparam int MM  = 147;
  localparam int PB  = 8;
  localparam int CB  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           frame_in;
  logic           frame_rdy;
  logic           cmd_req;
  logic           cmd_ack;
  logic [NSL-1:0] cmd_stream;
  logic [PB-1:0]  cmd_phase;
  logic           cmd_shift;
  logic           cmd_first;
  logic           overflow;

  always #5 clk = ~clk;

  src_phase_scheduler #(
    .NR_STREAMS(NS), .NR_STREAMS_LOG(NSL), .L(LL), .M(MM),
    .PHASE_BITS(PB), .CREDIT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_in(frame_in),
    .frame_rdy(frame_rdy), .cmd_req(cmd_req), .cmd_ack(cmd_ack),
    .cmd_stream(cmd_stream), .cmd_phase(cmd_phase), .cmd_shift(cmd_shift),
    .cmd_first(cmd_first), .overflow(overflow)
  );

  typedef struct packed {
    logic [NSL-1:0] stream;
    logic [PB-1:0]  phase;
    logic           shift;
    logic           first;
  } xfer_t;

  xfer_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_round = 0;

  always @(negedge clk) begin
    xfer_t x;
    if (!rst && cmd_req && cmd_ack) begin
      x.stream = cmd_stream;
      x.phase  = cmd_phase;
      x.shift  = cmd_shift;
      x.first  = cmd_first;
      q.push_back(x);
    end
  end

  function automatic xfer_t exp_xfer(input int k, input int r0);
    xfer_t x;
    int r, s, ph;
    r = r0 + k / NS;
    s = k % NS;
    ph = (r * MM) % LL;
    x.stream = NSL'(s);
    x.phase  = PB'(ph);
    x.shift  = (ph + MM >= LL);
    x.first  = (s == 0);
    return x;
  endfunction

  function automatic int rounds_until_stall(input int r0, input int credits);
    int n, ph, c;
    n = 0;
    c = credits;
    while (n < 1000) begin
      ph = ((r0 + n) * MM) % LL;
      if (ph + MM >= LL) begin
        if (c == 0) break;
        c--;
      end
      n++;
    end
    return n;
  endfunction

  task automatic cyc_rand();
    @(posedge clk); #1;
    cmd_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_in = 1'b1;
    @(posedge clk); #1;
    frame_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; cmd_ack = 1'b0; frame_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (cmd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", cmd_req); end
    n_tests++; if (cmd_stream !== 4'd0) begin n_fail++; $display("FAIL reset_stream: got %0d expected 0", cmd_stream); end
    n_tests++; if (cmd_phase !== 8'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", cmd_phase); end
    n_tests++; if ({cmd_shift, cmd_first} !== 2'b00) begin n_fail++; $display("FAIL reset_shift_first: got %b expected 00", {cmd_shift, cmd_first}); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_tests++; if (frame_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_frame_rdy: got %b expected 1", frame_rdy); end
  endtask

  task automatic test_first_round();
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; cmd_ack = 1'b1;
    q.delete();
    @(negedge clk);
    n_tests++; if (cmd_req !== 1'b0) begin n_fail++; $display("FAIL latency_c0: got req %b expected 0", cmd_req); end
    @(negedge clk);
    n_tests++; if (cmd_req !== 1'b0) begin n_fail++; $display("FAIL latency_c1: got req %b expected 0", cmd_req); end
    @(negedge clk);
    n_tests++; if ({cmd_req, cmd_first, cmd_stream} !== {1'b1, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL latency_c2: got req/first/stream %b/%b/%0d expected 1/1/0", cmd_req, cmd_first, cmd_stream);
    end
    for (int c = 0; c < 200 && q.size() < NS; c++) @(posedge clk);
    n_tests++; if (q.size() != NS) begin n_fail++; $display("FAIL round0_count: got %0d expected %0d", q.size(), NS); end
    for (int i = 0; i < q.size() && i < NS; i++) begin
      n_tests++;
      if (q[i] !== exp_xfer(i, 0)) begin n_fail++; $display("FAIL round0_cmd[%0d]: got %h expected %h", i, q[i], exp_xfer(i, 0)); end
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_tests++; if (q.size() != NS) begin n_fail++; $display("FAIL round0_stall_count: got %0d expected %0d", q.size(), NS); end
    n_tests++; if ({cmd_req, cmd_phase} !== {1'b0, 8'd147}) begin
      n_fail++; $display("FAIL round0_stall: got req/phase %b/%0d expected 0/147", cmd_req, cmd_phase);
    end
    m_round = 1;
  endtask

  task automatic test_credit();
    q.delete();
    pulse_frame();
    for (int c = 0; c < 200 && q.size() < NS; c++) @(posedge clk);
    n_tests++; if (q.size() != NS) begin n_fail++; $display("FAIL credit_count: got %0d expected %0d", q.size(), NS); end
    for (int i = 0; i < q.size() && i < NS; i++) begin
      n_tests++;
      if (q[i] !== exp_xfer(i, m_round)) begin n_fail++; $display("FAIL credit_cmd[%0d]: got %h expected %h", i, q[i], exp_xfer(i, m_round)); end
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_tests++; if (q.size() != NS) begin n_fail++; $display("FAIL credit_stall_count: got %0d expected %0d", q.size(), NS); end
    n_tests++; if ({cmd_req, cmd_phase} !== {1'b0, 8'd134}) begin
      n_fail++; $display("FAIL credit_stall: got req/phase %b/%0d expected 0/134", cmd_req, cmd_phase);
    end
    m_round = 2;
  endtask

  task automatic test_ack_stall();
    logic [13:0] snap;
    bit stalled;
    stalled = 1'b0;
    snap = '0;
    q.delete();
    pulse_frame();
    for (int c = 0; c < 600 && q.size() < NS; c++) begin
      @(posedge clk); #1;
      if (q.size() > 0) enable = 1'b0;
      if (!stalled && cmd_req && cmd_stream == 4'd3) begin
        cmd_ack = 1'b0;
        stalled = 1'b1;
        snap = {cmd_stream, cmd_phase, cmd_shift, cmd_first};
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_tests++;
          if ({cmd_req, cmd_stream, cmd_phase, cmd_shift, cmd_first} !== {1'b1, snap}) begin
            n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", k,
                               {cmd_req, cmd_stream, cmd_phase, cmd_shift, cmd_first}, {1'b1, snap});
          end
        end
      end else begin
        cmd_ack = 1'($urandom_range(0, 1));
      end
    end
    cmd_ack = 1'b1;
    n_tests++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL stall_seen: got %b expected 1", stalled); end
    n_tests++; if (q.size() != NS) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", q.size(), NS); end
    for (int i = 0; i < q.size() && i < NS; i++) begin
      n_tests++;
      if (q[i] !== exp_xfer(i, m_round)) begin n_fail++; $display("FAIL stall_cmd[%0d]: got %h expected %h", i, q[i], exp_xfer(i, m_round)); end
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({cmd_req, 32'(q.size())} !== {1'b0, 32'(NS)}) begin
      n_fail++; $display("FAIL enable_low_idle: got req/count %b/%0d expected 0/%0d", cmd_req, q.size(), NS);
    end
    m_round = 3;
  endtask

  task automatic test_overflow();
    int n;
    for (int k = 1; k <= 8; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      pulse_frame();
      @(negedge clk);
      n_tests++; if (frame_rdy !== (k < 7)) begin n_fail++; $display("FAIL ovf_frame_rdy[%0d]: got %b expected %b", k, frame_rdy, (k < 7)); end
      n_tests++; if (overflow !== (k >= 8)) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b expected %b", k, overflow, (k >= 8)); end
    end
    n = rounds_until_stall(m_round, 7);
    q.delete();
    @(posedge clk); #1;
    enable = 1'b1;
    for (int c = 0; c < n * 80 + 100 && q.size() < n * NS; c++) cyc_rand();
    cmd_ack = 1'b1;
    n_tests++; if (q.size() != n * NS) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected %0d", q.size(), n * NS); end
    for (int i = 0; i < q.size() && i < n * NS; i++) begin
      n_tests++;
      if (q[i] !== exp_xfer(i, m_round)) begin n_fail++; $display("FAIL ovf_drain_cmd[%0d]: got %h expected %h", i, q[i], exp_xfer(i, m_round)); end
    end
    repeat (20) cyc_rand();
    @(negedge clk);
    n_tests++; if (q.size() != n * NS) begin n_fail++; $display("FAIL ovf_drain_stall: got %0d expected %0d", q.size(), n * NS); end
    n_tests++; if ({cmd_req, overflow, frame_rdy} !== 3'b011) begin
      n_fail++; $display("FAIL ovf_after_drain: got req/ovf/rdy %b expected 011", {cmd_req, overflow, frame_rdy});
    end
    m_round += n;
  endtask

  task automatic test_coincident();
    int n;
    q.delete();
    pulse_frame();
    enable = 1'b0;
    for (int c = 0; c < 400 && q.size() < NS; c++) cyc_rand();
    n_tests++; if (q.size() != NS) begin n_fail++; $display("FAIL coinc_pre_count: got %0d expected %0d", q.size(), NS); end
    m_round += 1;
    repeat (5) @(posedge clk);
    pulse_frame();
    pulse_frame();
    q.delete();
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    frame_in = 1'b1;
    @(posedge clk); #1;
    frame_in = 1'b0;
    @(negedge clk);
    n_tests++; if (cmd_req !== 1'b1) begin n_fail++; $display("FAIL coinc_issue: got req %b expected 1", cmd_req); end
    n = 1 + rounds_until_stall(m_round + 1, 2);
    for (int c = 0; c < n * 80 + 100 && q.size() < n * NS; c++) cyc_rand();
    cmd_ack = 1'b1;
    n_tests++; if (q.size() != n * NS) begin n_fail++; $display("FAIL coinc_count: got %0d expected %0d", q.size(), n * NS); end
    for (int i = 0; i < q.size() && i < n * NS; i++) begin
      n_tests++;
      if (q[i] !== exp_xfer(i, m_round)) begin n_fail++; $display("FAIL coinc_cmd[%0d]: got %h expected %h", i, q[i], exp_xfer(i, m_round)); end
    end
    repeat (20) cyc_rand();
    @(negedge clk);
    n_tests++; if ({cmd_req, 32'(q.size())} !== {1'b0, 32'(n * NS)}) begin
      n_fail++; $display("FAIL coinc_stall: got req/count %b/%0d expected 0/%0d", cmd_req, q.size(), n * NS);
    end
    m_round += n;
  endtask

  task automatic test_reset_mid();
    bit found;
    int shifts;
    found = 1'b0;
    q.delete();
    pulse_frame();
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      if (cmd_req && cmd_stream == 4'd9) found = 1'b1;
      else cmd_ack = 1'($urandom_range(0, 1));
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach9: got %b expected 1", found); end
    rst = 1'b1;
    cmd_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if ({cmd_req, cmd_stream, cmd_phase, cmd_shift, cmd_first} !== 15'd0) begin
      n_fail++; $display("FAIL rstmid_cmd: got %h expected 0", {cmd_req, cmd_stream, cmd_phase, cmd_shift, cmd_first});
    end
    n_tests++; if ({overflow, frame_rdy} !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_flags: got ovf/rdy %b expected 01", {overflow, frame_rdy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    enable = 1'b1;
    for (int c = 0; c < 20000 && q.size() < 160 * NS; c++) begin
      @(posedge clk); #1;
      cmd_ack  = ($urandom_range(0, 3) != 0);
      frame_in = frame_rdy && ($urandom_range(0, 3) == 0);
      if (q.size() > 159 * NS) enable = 1'b0;
    end
    frame_in = 1'b0;
    cmd_ack  = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_tests++; if (q.size() != 160 * NS) begin n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", q.size(), 160 * NS); end
    shifts = 0;
    for (int i = 0; i < q.size() && i < 160 * NS; i++) begin
      n_tests++;
      if (q[i] !== exp_xfer(i, 0)) begin n_fail++; $display("FAIL rstmid_cmd[%0d]: got %h expected %h", i, q[i], exp_xfer(i, 0)); end
      if (q[i].first && q[i].shift) shifts++;
    end
    n_tests++; if (shifts != 147) begin n_fail++; $display("FAIL rstmid_shift_rounds: got %0d expected 147", shifts); end
    n_tests++; if ({cmd_req, cmd_phase, overflow} !== 10'd0) begin
      n_fail++; $display("FAIL rstmid_final: got req/phase/ovf %b/%0d/%b expected 0/0/0", cmd_req, cmd_phase, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_credit();
    test_ack_stall();
    test_overflow();
    test_coincident();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
